keypad_scanner: RTL

- Upstream stage for the stopwatch/calculator controller.
- Drives the 4x4 matrix keypad columns and samples the rows.
- Debounces the press and the release.
- Emits one key_valid strobe with a 4-bit key code per physical press. The controller consumes this strobe instead of decoding raw row/column lines itself.

---
 rtl/keypad_scanner.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces press and
// release, and emits a single key_valid strobe with a 4-bit key code per press.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 500000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [3:0] linhas,
    output logic [3:0] colunas,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       ROWS_IDLE = 4'b1111;

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

    state_t           r_state, w_state_next;
    logic [3:0]       r_sync1, r_rows_s;
    logic [1:0]       r_col, w_col_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [3:0]       r_pat, w_pat_next;
    logic [3:0]       r_code, w_code_next;
    logic             r_valid, w_valid_next;
    logic             w_idle;
    logic [1:0]       w_row;
    logic [3:0]       w_decoded;

    // Row lines come straight off the keypad; two flops before any decision uses them.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= ROWS_IDLE;
            r_rows_s <= ROWS_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_sync1  <= linhas;
            r_rows_s <= r_sync1;
        end
    end

    assign w_idle = (r_rows_s == ROWS_IDLE);

    always_comb begin
        w_row     = 2'd3;
        w_decoded = 4'h0;
        if (!r_pat[0])      w_row = 2'd0;
        else if (!r_pat[1]) w_row = 2'd1;
        else if (!r_pat[2]) w_row = 2'd2;
        case ({r_col, w_row})
            4'b00_00: w_decoded = 4'h1;
            4'b00_01: w_decoded = 4'h4;
            4'b00_10: w_decoded = 4'h7;
            4'b00_11: w_decoded = 4'hE;
            4'b01_00: w_decoded = 4'h2;
            4'b01_01: w_decoded = 4'h5;
            4'b01_10: w_decoded = 4'h8;
            4'b01_11: w_decoded = 4'h0;
            4'b10_00: w_decoded = 4'h3;
            4'b10_01: w_decoded = 4'h6;
            4'b10_10: w_decoded = 4'h9;
            4'b10_11: w_decoded = 4'hF;
            4'b11_00: w_decoded = 4'hA;
            4'b11_01: w_decoded = 4'hB;
            4'b11_10: w_decoded = 4'hC;
            default:  w_decoded = 4'hD;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_col_next   = r_col;
        w_cnt_next   = r_cnt;
        w_pat_next   = r_pat;
        w_code_next  = r_code;
        w_valid_next = 1'b0;
        unique case (r_state)
            ST_SCAN: begin
                if (r_cnt == SCAN_LAST) begin
                    w_cnt_next = '0;
                    if (!w_idle) begin
                        w_pat_next   = r_rows_s;
                        w_state_next = ST_DEBOUNCE;
                    end else begin
                        w_col_next = r_col + 2'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (r_rows_s == r_pat) begin
                    if (r_cnt == DEB_LAST) begin
                        w_state_next = ST_PRESSED;
                        w_code_next  = w_decoded;
                        w_valid_next = 1'b1;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end else if (w_idle) begin
                    w_state_next = ST_SCAN;
                    w_col_next   = r_col + 2'd1;
                    w_cnt_next   = '0;
                end else begin
                    w_pat_next = r_rows_s;
                    w_cnt_next = '0;
                end
            end
            ST_PRESSED: begin
                // The idle sample that ends PRESSED is the first of the release run.
                if (w_idle) begin
                    w_state_next = ST_RELEASE;
                    w_cnt_next   = CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (w_idle) begin
                    if (r_cnt == DEB_LAST) begin
                        w_state_next = ST_SCAN;
                        w_col_next   = r_col + 2'd1;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            default: w_state_next = ST_SCAN;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SCAN;
            r_col   <= 2'd0;
            r_cnt   <= '0;
            r_pat   <= ROWS_IDLE;
            r_code  <= 4'h0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_col   <= w_col_next;
            r_cnt   <= w_cnt_next;
            r_pat   <= w_pat_next;
            r_code  <= w_code_next;
            r_valid <= w_valid_next;
        end
    end

    assign colunas   = ~(4'b0001 << r_col);
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = (r_state == ST_PRESSED) || (r_state == ST_RELEASE);

endmodule
